lvds_rx_align_ctrl: RTL and testbench

Word-alignment sequencer for the LVDS receiver. It runs after PLL/DPA/FIFO/CDA reset initialisation has completed.
- Aligns channels one at a time: pulses rx_bitslip_ctrl on a channel until its deserialised word matches the training pattern for MATCH_CNT consecutive cycles, then moves to the next channel.
- Reports aligned, failed, or lock-lost status to the link bring-up logic.

---
 rtl/lvds_rx_align_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_lvds_rx_align_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_rx_align_ctrl.sv
// LVDS receiver word-alignment sequencer: walks each channel, issuing bitslip
// pulses until its word matches the training pattern, then reports status.
//
// state  | meaning
// IDLE   | waiting for start
// SELECT | pick channel ch_idx, confirm its DPA lock
// SETTLE | let deserialiser output settle after select/bitslip
// CHECK  | compare channel word with training pattern
// SLIP   | bitslip pulse on current channel
// NEXT   | mark channel aligned, advance or finish
// DONE   | all channels aligned, watching DPA locks
// FAIL   | alignment failed on fail_ch
module lvds_rx_align_ctrl #(
    parameter int                NUM_CH        = 4,
    parameter int                DATA_W        = 10,
    parameter logic [DATA_W-1:0] TRAIN_PATTERN = 10'h3E0,
    parameter int                SETTLE_CYC    = 8,
    parameter int                MATCH_CNT     = 4,
    parameter int                MAX_SLIP      = 10,
    localparam int               CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NUM_CH*DATA_W-1:0] rx_data,
    input  logic [NUM_CH-1:0]        rx_dpa_locked,
    output logic [NUM_CH-1:0]        rx_bitslip_ctrl,
    output logic [NUM_CH-1:0]        ch_aligned,
    output logic                     busy,
    output logic                     align_done,
    output logic                     align_fail,
    output logic [CH_W-1:0]          fail_ch,
    output logic                     lock_lost
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int MAT_W = $clog2(MATCH_CNT + 1);
    localparam int SLP_W = $clog2(MAX_SLIP + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        SLIP   = 3'd4,
        NEXT   = 3'd5,
        DONE   = 3'd6,
        FAIL   = 3'd7
    } state_t;

    state_t             state, state_n;
    logic [CH_W-1:0]    ch_idx, ch_idx_n;
    logic [SLP_W-1:0]   slip_cnt, slip_cnt_n;
    logic [SET_W-1:0]   settle_cnt, settle_cnt_n;
    logic [MAT_W-1:0]   match_cnt, match_cnt_n;
    logic [NUM_CH-1:0]  bitslip_n, ch_aligned_n;
    logic               busy_n, align_done_n, align_fail_n, lock_lost_n;
    logic [CH_W-1:0]    fail_ch_n;
    logic               restart, cur_locked, cur_match;
    logic [DATA_W-1:0]  word [NUM_CH];

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            word[c] = rx_data[c*DATA_W +: DATA_W];
        end
    end

    assign cur_locked = rx_dpa_locked[ch_idx];
    assign cur_match  = (word[ch_idx] == TRAIN_PATTERN);

    always_comb begin
        state_n      = state;
        ch_idx_n     = ch_idx;
        slip_cnt_n   = slip_cnt;
        settle_cnt_n = settle_cnt;
        match_cnt_n  = match_cnt;
        bitslip_n    = '0;
        ch_aligned_n = ch_aligned;
        busy_n       = 1'b1;
        align_done_n = align_done;
        align_fail_n = align_fail;
        fail_ch_n    = fail_ch;
        lock_lost_n  = 1'b0;
        restart      = 1'b0;

        case (state)
            IDLE: begin
                busy_n  = 1'b0;
                restart = start;
            end
            SELECT: begin
                if (!cur_locked) begin
                    state_n = FAIL;
                end else begin
                    slip_cnt_n   = '0;
                    settle_cnt_n = '0;
                    state_n      = SETTLE;
                end
            end
            SETTLE: begin
                if (!cur_locked) begin
                    state_n = FAIL;
                end else if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
                    match_cnt_n = '0;
                    state_n     = CHECK;
                end else begin
                    settle_cnt_n = settle_cnt + 1'b1;
                end
            end
            CHECK: begin
                // lock loss outranks both the match and the slip decision
                if (!cur_locked) begin
                    state_n = FAIL;
                end else if (cur_match) begin
                    match_cnt_n = match_cnt + 1'b1;
                    if (match_cnt == MAT_W'(MATCH_CNT - 1)) begin
                        state_n = NEXT;
                    end
                end else if (slip_cnt == SLP_W'(MAX_SLIP)) begin
                    state_n = FAIL;
                end else begin
                    // registered so the pulse coincides with the SLIP state
                    bitslip_n = NUM_CH'(1) << ch_idx;
                    state_n   = SLIP;
                end
            end
            SLIP: begin
                if (!cur_locked) begin
                    state_n = FAIL;
                end else begin
                    slip_cnt_n   = slip_cnt + 1'b1;
                    settle_cnt_n = '0;
                    state_n      = SETTLE;
                end
            end
            NEXT: begin
                ch_aligned_n[ch_idx] = 1'b1;
                if (ch_idx == CH_W'(NUM_CH - 1)) begin
                    state_n = DONE;
                end else begin
                    ch_idx_n = ch_idx + 1'b1;
                    state_n  = SELECT;
                end
            end
            DONE: begin
                busy_n       = 1'b0;
                align_done_n = 1'b1;
                if (!(&rx_dpa_locked)) begin
                    lock_lost_n  = 1'b1;
                    align_done_n = 1'b0;
                    ch_aligned_n = '0;
                    state_n      = IDLE;
                end else begin
                    restart = start;
                end
            end
            FAIL: begin
                busy_n       = 1'b0;
                align_fail_n = 1'b1;
                fail_ch_n    = ch_idx;
                restart      = start;
            end
            default: begin
                state_n      = IDLE;
                busy_n       = 1'b0;
                ch_aligned_n = '0;
                align_done_n = 1'b0;
                align_fail_n = 1'b0;
                fail_ch_n    = '0;
            end
        endcase

        if (restart) begin
            ch_idx_n     = '0;
            ch_aligned_n = '0;
            align_done_n = 1'b0;
            align_fail_n = 1'b0;
            fail_ch_n    = '0;
            state_n      = SELECT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            ch_idx          <= '0;
            slip_cnt        <= '0;
            settle_cnt      <= '0;
            match_cnt       <= '0;
            rx_bitslip_ctrl <= '0;
            ch_aligned      <= '0;
            busy            <= 1'b0;
            align_done      <= 1'b0;
            align_fail      <= 1'b0;
            fail_ch         <= '0;
            lock_lost       <= 1'b0;
        end else begin
            state           <= state_n;
            ch_idx          <= ch_idx_n;
            slip_cnt        <= slip_cnt_n;
            settle_cnt      <= settle_cnt_n;
            match_cnt       <= match_cnt_n;
            rx_bitslip_ctrl <= bitslip_n;
            ch_aligned      <= ch_aligned_n;
            busy            <= busy_n;
            align_done      <= align_done_n;
            align_fail      <= align_fail_n;
            fail_ch         <= fail_ch_n;
            lock_lost       <= lock_lost_n;
        end
    end

endmodule

// File: tb/tb_lvds_rx_align_ctrl.sv
// Bench for lvds_rx_align_ctrl: table of alignment scenarios plus hand-written
// corner sequences; expected bitslip pulses are queued and matched as they occur.
module tb_lvds_rx_align_ctrl;

    localparam int          NCH      = 4;
    localparam int          MAX_SLIP = 10;
    localparam logic [9:0]  TP       = 10'h3E0;
    localparam logic [9:0]  TP_ROT   = 10'h1F0;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [39:0]     rx_data;
    logic [3:0]      locked;
    logic [3:0]      rx_bitslip_ctrl;
    logic [3:0]      ch_aligned;
    logic            busy, align_done, align_fail, lock_lost;
    logic [1:0]      fail_ch;

    lvds_rx_align_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .rx_data         (rx_data),
        .rx_dpa_locked   (locked),
        .rx_bitslip_ctrl (rx_bitslip_ctrl),
        .ch_aligned      (ch_aligned),
        .busy            (busy),
        .align_done      (align_done),
        .align_fail      (align_fail),
        .fail_ch         (fail_ch),
        .lock_lost       (lock_lost)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][7:0] need;      // slips each channel needs before it matches
        logic [3:0]      never;     // channels that never match
        logic            exp_fail;
        logic [1:0]      exp_fail_ch;
        logic [3:0]      exp_aligned;
        int              exp_cycles; // edges from start sample to done/fail flag
    } vec_t;

    typedef struct packed {
        int         cyc;
        logic [3:0] mask;
    } pulse_t;

    pulse_t          exp_q [$];
    vec_t            vecs [6];
    int              n_checks = 0;
    int              n_fail   = 0;
    int              cyc      = 0;
    int              got  [NCH];
    int              base [NCH];
    logic [3:0][7:0] need;
    logic [3:0]      never;
    logic [3:0]      glitch;

    initial for (int c = 0; c < NCH; c++) got[c] = 0;

    always @(posedge clk) cyc++;

    // channel model: a word matches once it has received enough bitslips
    always_comb begin
        rx_data = '0;
        for (int c = 0; c < NCH; c++) begin
            if (!never[c] && !glitch[c] && (got[c] - base[c]) >= int'(need[c]))
                rx_data[c*10 +: 10] = TP;
            else
                rx_data[c*10 +: 10] = TP_ROT;
        end
    end

    always @(negedge clk) begin
        if (!rst && rx_bitslip_ctrl != 4'b0) begin
            pulse_t e;
            for (int c = 0; c < NCH; c++) if (rx_bitslip_ctrl[c]) got[c]++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL bitslip_unexpected: actual mask %b at cycle %0d, required no pulse",
                         rx_bitslip_ctrl, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.mask != rx_bitslip_ctrl) begin
                    n_fail++;
                    $display("FAIL bitslip_pulse: actual mask %b at cycle %0d, required mask %b at cycle %0d",
                             rx_bitslip_ctrl, cyc, e.mask, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic vec_t mk(input int n0, input int n1, input int n2, input int n3,
                                input logic [3:0] nv, input logic f, input int fch,
                                input logic [3:0] al, input int cycles);
        vec_t v;
        v.need[0]     = 8'(n0);
        v.need[1]     = 8'(n1);
        v.need[2]     = 8'(n2);
        v.need[3]     = 8'(n3);
        v.never       = nv;
        v.exp_fail    = f;
        v.exp_fail_ch = 2'(fch);
        v.exp_aligned = al;
        v.exp_cycles  = cycles;
        return v;
    endfunction

    task automatic set_model(input logic [3:0][7:0] n, input logic [3:0] nv);
        need  = n;
        never = nv;
        for (int c = 0; c < NCH; c++) base[c] = got[c];
    endtask

    // returns at a negedge with cyc == t0, i.e. just after the edge that sampled start
    task automatic pulse_start(output int t0);
        @(negedge clk);
        start = 1'b1;
        t0    = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_flag(input int budget, output int at, output logic pb);
        at = -1;
        pb = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (align_done || align_fail) begin
                at = cyc;
                break;
            end
            pb = busy;
        end
        if (at < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL flag_timeout: actual no done/fail within %0d cycles, required a flag", budget);
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int   t0, at, b, ns;
        logic pb;
        set_model(v.need, v.never);
        pulse_start(t0);
        check({name, "_restart_clear"}, int'({align_done, align_fail, fail_ch, ch_aligned}), 0);
        b = 0;
        for (int c = 0; c < NCH; c++) begin
            ns = v.never[c] ? MAX_SLIP : int'(v.need[c]);
            for (int j = 0; j < ns; j++)
                exp_q.push_back('{cyc: t0 + b + 10 + 10*j, mask: 4'(1 << c)});
            if (v.never[c]) break;
            b += 14 + 10*ns;
        end
        wait_flag(v.exp_cycles + 40, at, pb);
        check({name, "_flag_cycle"}, at - t0, v.exp_cycles);
        check({name, "_busy_before"}, int'(pb), 1);
        check({name, "_busy_after"}, int'(busy), 0);
        check({name, "_done"}, int'(align_done), int'(!v.exp_fail));
        check({name, "_fail"}, int'(align_fail), int'(v.exp_fail));
        check({name, "_fail_ch"}, int'(fail_ch), int'(v.exp_fail_ch));
        check({name, "_ch_aligned"}, int'(ch_aligned), int'(v.exp_aligned));
        check({name, "_pulses_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual simulation still running, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int   t0, at;
        logic pb;

        vecs[0] = mk(0, 0, 0, 0,  4'b0000, 1'b0, 0, 4'hF,    57);
        vecs[1] = mk(0, 0, 3, 0,  4'b0000, 1'b0, 0, 4'hF,    87);
        vecs[2] = mk(0, 0, 0, 0,  4'b0010, 1'b1, 1, 4'b0001, 125);
        vecs[3] = mk(1, 2, 0, 1,  4'b0000, 1'b0, 0, 4'hF,    97);
        vecs[4] = mk(0, 0, 0, 10, 4'b0000, 1'b0, 0, 4'hF,    157);
        vecs[5] = mk(0, 0, 0, 0,  4'b0001, 1'b1, 0, 4'b0000, 111);

        rst    = 1'b1;
        start  = 1'b0;
        locked = 4'hF;
        glitch = 4'b0;
        set_model('0, 4'b0);
        repeat (3) @(negedge clk);
        check("reset_outputs",
              int'({rx_bitslip_ctrl, ch_aligned, busy, align_done, align_fail, fail_ch, lock_lost}), 0);
        rst = 1'b0;

        // reset while ch1 is in CHECK
        pulse_start(t0);
        while (cyc < t0 + 25) @(negedge clk);
        check("pre_reset_aligned", int'(ch_aligned), 1);
        check("pre_reset_busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1 check("async_reset_outputs",
                 int'({rx_bitslip_ctrl, ch_aligned, busy, align_done, align_fail, fail_ch, lock_lost}), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_vec(vecs[0], "all_aligned");
        run_vec(vecs[1], "ch2_3slips");
        run_vec(vecs[2], "ch1_never");
        run_vec(vecs[3], "mixed_slips");
        run_vec(vecs[4], "ch3_max_slip");
        run_vec(vecs[5], "ch0_never");

        // one-cycle pattern break on ch0 after 3 matches, plus starts while busy
        set_model('0, 4'b0);
        pulse_start(t0);
        exp_q.push_back('{cyc: t0 + 13, mask: 4'b0001});
        at = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            glitch = (cyc == t0 + 12) ? 4'b0001 : 4'b0000;
            start  = (cyc == t0 + 5) || (cyc == t0 + 30);
            if (align_done || align_fail) begin
                at = cyc;
                break;
            end
        end
        glitch = 4'b0;
        start  = 1'b0;
        check("glitch_done_cycle", at - t0, 70);
        check("glitch_ch_aligned", int'(ch_aligned), 15);
        check("glitch_pulses_left", exp_q.size(), 0);
        exp_q.delete();

        // ch3 loses DPA lock during its SETTLE
        pulse_start(t0);
        at = -1;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (cyc == t0 + 45) locked = 4'b0111;
            if (align_done || align_fail) begin
                at = cyc;
                break;
            end
        end
        locked = 4'hF;
        check("settle_lock_fail_cycle", at - t0, 47);
        check("settle_lock_fail", int'(align_fail), 1);
        check("settle_lock_fail_ch", int'(fail_ch), 3);
        check("settle_lock_aligned", int'(ch_aligned), 7);

        // in DONE: lock loss and start together, lock loss wins
        run_vec(vecs[0], "pre_lock_loss");
        @(negedge clk);
        locked = 4'b1110;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        locked = 4'hF;
        check("lock_lost_pulse", int'(lock_lost), 1);
        check("lock_lost_done", int'(align_done), 0);
        check("lock_lost_aligned", int'(ch_aligned), 0);
        @(negedge clk);
        check("lock_lost_single", int'(lock_lost), 0);
        check("lock_lost_idle", int'(busy), 0);

        run_vec(vecs[1], "after_lock_loss");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
